// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pattern modes, RGB444 payload type and colour helpers.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned BOX_SIZE = 32;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CHAN_W   = 4;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_BOX      = 2'd3
  } pat_e;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb444_t;

  localparam rgb444_t C_WHITE   = rgb444_t'(12'hFFF);
  localparam rgb444_t C_YELLOW  = rgb444_t'(12'hFF0);
  localparam rgb444_t C_CYAN    = rgb444_t'(12'h0FF);
  localparam rgb444_t C_GREEN   = rgb444_t'(12'h0F0);
  localparam rgb444_t C_MAGENTA = rgb444_t'(12'hF0F);
  localparam rgb444_t C_RED     = rgb444_t'(12'hF00);
  localparam rgb444_t C_BLUE    = rgb444_t'(12'h00F);
  localparam rgb444_t C_BLACK   = rgb444_t'(12'h000);

  // Bar colour from a comparison chain on the x coordinate; no divider.
  function automatic rgb444_t bar_colour(input logic [COORD_W-1:0] sx);
    if      (sx < COORD_W'(1 * BAR_W)) return C_WHITE;
    else if (sx < COORD_W'(2 * BAR_W)) return C_YELLOW;
    else if (sx < COORD_W'(3 * BAR_W)) return C_CYAN;
    else if (sx < COORD_W'(4 * BAR_W)) return C_GREEN;
    else if (sx < COORD_W'(5 * BAR_W)) return C_MAGENTA;
    else if (sx < COORD_W'(6 * BAR_W)) return C_RED;
    else if (sx < COORD_W'(7 * BAR_W)) return C_BLUE;
    else                               return C_BLACK;
  endfunction

  // One bounce step on an axis: returns {dir, pos}; reverses at 0 and at lim.
  function automatic logic [COORD_W:0] bounce_step(input logic [COORD_W-1:0] pos,
                                                   input logic dir,
                                                   input logic [COORD_W-1:0] lim);
    if (dir && pos == lim)        return {1'b0, lim - COORD_W'(1)};
    else if (!dir && pos == '0)   return {1'b1, COORD_W'(1)};
    else if (dir)                 return {1'b1, pos + COORD_W'(1)};
    else                          return {1'b0, pos - COORD_W'(1)};
  endfunction

endpackage

// File: rtl/vga_box_motion.sv
// Bouncing-box position/direction state, stepped once per frame, plus the box hit test.
module vga_box_motion
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  output logic               in_box_c
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE - BOX_SIZE);

  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;

  always_comb begin
    {dir_x_d, bx_d} = {dir_x_q, bx_q};
    {dir_y_d, by_d} = {dir_y_q, by_q};
    if (step) begin
      {dir_x_d, bx_d} = bounce_step(bx_q, dir_x_q, X_LIM);
      {dir_y_d, by_d} = bounce_step(by_q, dir_y_q, Y_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q    <= '0;
      by_q    <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      bx_q    <= bx_d;
      by_q    <= by_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  // Widened compare so bx+BOX_SIZE cannot wrap.
  assign in_box_c = (sx >= bx_q) && ((COORD_W+1)'(sx) < (COORD_W+1)'(bx_q) + (COORD_W+1)'(BOX_SIZE))
                 && (sy >= by_q) && ((COORD_W+1)'(sy) < (COORD_W+1)'(by_q) + (COORD_W+1)'(BOX_SIZE));

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage RGB444 test-pattern generator aligned with delayed syncs/DE.
// Define BOUNCE_BOX_EN to build the animated box (mode 3); otherwise mode 3 renders bars.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       i_VGA_CLOCK,
  input  logic       i_rst_n,
  input  logic       i_de,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [9:0] i_Sx,
  input  logic [9:0] i_Sy,
  input  logic [1:0] i_mode,
  output logic       o_de,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b
);

  logic [COORD_W-1:0] sx1_q, sx1_d, sy1_q, sy1_d;
  logic               de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  pat_e               mode_q, mode_d;
  logic               de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  rgb444_t            rgb2_q, rgb2_d;
  rgb444_t            colour_c;
  logic               frame_start_c;

  // vs1_q doubles as the registered vsync for edge detection.
  assign frame_start_c = vs1_q & ~i_vsync;

`ifdef BOUNCE_BOX_EN
  logic in_box_c;

  vga_box_motion u_box (
    .clk      (i_VGA_CLOCK),
    .rst_n    (i_rst_n),
    .step     (frame_start_c),
    .sx       (sx1_q),
    .sy       (sy1_q),
    .in_box_c (in_box_c)
  );
`else
  logic unused_sy_c;
  assign unused_sy_c = ^{sy1_q[9], sy1_q[4:0]};
`endif

  always_comb begin
    colour_c = C_BLACK;
    case (mode_q)
      PAT_BARS:     colour_c = bar_colour(sx1_q);
      PAT_CHECKER:  colour_c = (sx1_q[5] ^ sy1_q[5]) ? C_WHITE : C_BLACK;
      PAT_GRADIENT: colour_c = '{r: sx1_q[9:6], g: sy1_q[8:5], b: ~sx1_q[9:6]};
`ifdef BOUNCE_BOX_EN
      PAT_BOX:      colour_c = in_box_c ? C_RED : C_BLUE;
`endif
      default:      colour_c = bar_colour(sx1_q);
    endcase
  end

  always_comb begin
    sx1_d  = i_Sx;
    sy1_d  = i_Sy;
    de1_d  = i_de;
    hs1_d  = i_hsync;
    vs1_d  = i_vsync;
    mode_d = frame_start_c ? pat_e'(i_mode) : mode_q;
    de2_d  = de1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    rgb2_d = de1_q ? colour_c : C_BLACK;
  end

  always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sx1_q  <= '0;
      sy1_q  <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      mode_q <= PAT_BARS;
      de2_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      rgb2_q <= C_BLACK;
    end else begin
      sx1_q  <= sx1_d;
      sy1_q  <= sy1_d;
      de1_q  <= de1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      mode_q <= mode_d;
      de2_q  <= de2_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      rgb2_q <= rgb2_d;
    end
  end

  assign o_de    = de2_q;
  assign o_hsync = hs2_q;
  assign o_vsync = vs2_q;
  assign o_r     = rgb2_q.r;
  assign o_g     = rgb2_q.g;
  assign o_b     = rgb2_q.b;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: per-cycle compare against a frame-level model plus literal probes.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_de, i_hsync, i_vsync;
  logic [9:0] i_Sx, i_Sy;
  logic [1:0] i_mode;
  logic       o_de, o_hsync, o_vsync;
  logic [3:0] o_r, o_g, o_b;

  int n_checks = 0;
  int n_fail   = 0;

  vga_pattern_gen dut (
    .i_VGA_CLOCK (clk),
    .i_rst_n     (rst_n),
    .i_de        (i_de),
    .i_hsync     (i_hsync),
    .i_vsync     (i_vsync),
    .i_Sx        (i_Sx),
    .i_Sy        (i_Sy),
    .i_mode      (i_mode),
    .o_de        (o_de),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b)
  );

  always #20 clk = ~clk;

  // ---------------- frame-level reference model ----------------
  function automatic logic [11:0] bar_of(input int sx);
    case (sx / 80)
      0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
      4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
    endcase
  endfunction

  // Box position after n frame starts: triangle wave between 0 and lim.
  function automatic int tri_wave(input int n, input int lim);
    int p;
    p = n % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [11:0] model_pix(input int sx, input int sy, input int mode, input int frames);
    int r, g, bx, by;
    case (mode)
      0: return bar_of(sx);
      1: return ((((sx / 32) + (sy / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2: begin
        r = (sx / 64) % 16;
        g = (sy / 32) % 16;
        return {4'(r), 4'(g), 4'(15 - r)};
      end
      default: begin
`ifdef BOUNCE_BOX_EN
        bx = tri_wave(frames, 608);
        by = tri_wave(frames, 448);
        return (sx >= bx && sx < bx + 32 && sy >= by && sy < by + 32) ? 12'hF00 : 12'h00F;
`else
        bx = frames; by = bx;
        return bar_of(sx);
`endif
      end
    endcase
  endfunction

  localparam logic [14:0] RST_OUT = {1'b0, 1'b1, 1'b1, 12'h000};

  logic        m_prev_vs;
  int          m_mode, m_frames;
  logic        fs_m;
  int          mode_now, frames_now;
  logic [14:0] exp1, exp2;

  assign fs_m       = m_prev_vs & ~i_vsync;
  assign mode_now   = fs_m ? int'(i_mode) : m_mode;
  assign frames_now = m_frames + (fs_m ? 1 : 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_vs <= 1'b1;
      m_mode    <= 0;
      m_frames  <= 0;
      exp1      <= RST_OUT;
      exp2      <= RST_OUT;
    end else begin
      m_prev_vs <= i_vsync;
      m_mode    <= mode_now;
      m_frames  <= frames_now;
      exp1      <= {i_de, i_hsync, i_vsync,
                    i_de ? model_pix(int'(i_Sx), int'(i_Sy), mode_now, frames_now) : 12'h000};
      exp2      <= exp1;
    end
  end

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    n_checks++;
    if ({o_de, o_hsync, o_vsync, o_r, o_g, o_b} !== exp2) begin
      n_fail++;
      $display("FAIL pipe t=%0t got de/hs/vs/rgb=%b%b%b/%h expected %b%b%b/%h", $time,
               o_de, o_hsync, o_vsync, {o_r, o_g, o_b}, exp2[14], exp2[13], exp2[12], exp2[11:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic de, input logic hs, input logic vs, input int sx, input int sy);
    i_de = de; i_hsync = hs; i_vsync = vs; i_Sx = 10'(sx); i_Sy = 10'(sy);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Drive one active pixel, then read its colour two edges later.
  task automatic probe(input string name, input int sx, input int sy, input logic [11:0] want);
    cyc(1'b1, 1'b1, 1'b1, sx, sy);
    cyc(1'b0, 1'b1, 1'b1, 700, sy);
    check(name, {o_r, o_g, o_b}, want);
  endtask

  task automatic vsync_pulse();
    cyc(1'b0, 1'b1, 1'b1, 700, 489);
    cyc(1'b0, 1'b1, 1'b0, 700, 490);
    cyc(1'b0, 1'b1, 1'b0, 700, 491);
    cyc(1'b0, 1'b1, 1'b1, 700, 492);
  endtask

  task automatic line(input int sy, input int n);
    for (int sx = 0; sx < n; sx++)
      cyc(sx < 640 && sy < 480, !(sx >= 656 && sx < 752), 1'b1, sx, sy);
  endtask

`ifdef BOUNCE_BOX_EN
  localparam bit BOX = 1'b1;
`else
  localparam bit BOX = 1'b0;
`endif

  initial begin
    rst_n = 1'b0;
    i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1; i_Sx = 10'd0; i_Sy = 10'd0; i_mode = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_de",  {11'd0, o_de},    12'd0);
    check("rst_hs",  {11'd0, o_hsync}, 12'd1);
    check("rst_vs",  {11'd0, o_vsync}, 12'd1);
    check("rst_rgb", {o_r, o_g, o_b},  12'h000);
    #3 rst_n = 1'b1;

    // Bars, including a sync-exercising full line.
    line(10, 800);
    probe("bar_0",   0,   10, 12'hFFF);
    probe("bar_79",  79,  10, 12'hFFF);
    probe("bar_80",  80,  10, 12'hFF0);
    probe("bar_160", 160, 10, 12'h0FF);
    probe("bar_479", 479, 10, 12'hF00);
    probe("bar_480", 480, 10, 12'h00F);
    probe("bar_639", 639, 10, 12'h000);
    cyc(1'b0, 1'b1, 1'b1, 700, 10);
    cyc(1'b0, 1'b1, 1'b1, 700, 10);
    check("blank_rgb", {o_r, o_g, o_b}, 12'h000);
    check("blank_de",  {11'd0, o_de},   12'd0);

    // Mid-frame mode change is deferred to the next frame start.
    line(200, 100);
    i_mode = 2'd1;
    probe("defer_bar", 80, 250, 12'hFF0);
    vsync_pulse();
    probe("chk_0_0",   0,  0,  12'h000);
    probe("chk_32_0",  32, 0,  12'hFFF);
    probe("chk_32_32", 32, 32, 12'h000);

    i_mode = 2'd2;
    vsync_pulse();
    probe("grad_100",  100, 100, 12'h13E);
    probe("grad_639",  639, 479, 12'h9E6);

    // Box mode: third frame start, box at (3,3).
    i_mode = 2'd3;
    vsync_pulse();
    probe("box_in_tl",  3,  3,  BOX ? 12'hF00 : 12'hFFF);
    probe("box_in_br",  34, 34, BOX ? 12'hF00 : 12'hFFF);
    probe("box_out_r",  35, 3,  BOX ? 12'h00F : 12'hFFF);
    probe("box_out_l",  2,  3,  BOX ? 12'h00F : 12'hFFF);
    probe("box_out_b",  3,  35, BOX ? 12'h00F : 12'hFFF);
    line(20, 800);

    repeat (605) begin
      vsync_pulse();
      cyc(1'b1, 1'b1, 1'b1, 600, 290);
    end
    // Frame 608: bx at its limit, by already reflected to 288.
    probe("f608_in",  608, 288, BOX ? 12'hF00 : 12'h000);
    probe("f608_out", 607, 288, BOX ? 12'h00F : 12'h000);
    vsync_pulse();
    // Frame 609: bx reversed to 607, by 287.
    probe("f609_in_tl", 607, 287, BOX ? 12'hF00 : 12'h000);
    probe("f609_in_br", 638, 318, BOX ? 12'hF00 : 12'h000);
    probe("f609_out_l", 606, 287, BOX ? 12'h00F : 12'h000);
    probe("f609_out_r", 639, 287, BOX ? 12'h00F : 12'h000);
    line(300, 800);

    // Asynchronous reset mid-frame, then bars until the next frame start.
    line(100, 120);
    #5 rst_n = 1'b0;
    #1;
    check("arst_de",  {11'd0, o_de},    12'd0);
    check("arst_hs",  {11'd0, o_hsync}, 12'd1);
    check("arst_rgb", {o_r, o_g, o_b},  12'h000);
    @(negedge clk);
    #3 rst_n = 1'b1;
    probe("post_rst_bar", 80, 0, 12'hFF0);
    line(101, 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
